mipi_dphy_tx_hs_seq: RTL

- Per-lane MIPI D-PHY high-speed transmit sequencer. It runs in the byte-clock domain (dphy_clk, the div-4 BUFR output of the D-PHY clock generator).
- Converts a byte stream into the LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trail → LP-11 sequence.
- Drives the LP pad controls plus the tristate enable and parallel byte of the downstream OSERDES (clocked by oserdes_clk/oserdes_clkdiv).

---
 rtl/mipi_dphy_tx_hs_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mipi_dphy_tx_hs_seq.sv
// mipi_dphy_tx_hs_seq: per-lane MIPI D-PHY high-speed transmit sequencer.
// Runs in the byte-clock domain (dphy_clk). Turns a byte stream into the
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11
// lane sequence and drives the LP pad levels plus the OSERDES byte/enable.
//
// Ports:
//   clk             byte clock
//   reset           asynchronous active-high reset (enters STOP at once)
//   s_data/s_last/s_valid/s_ready  payload byte stream (bit0 serialized first)
//   hs_oe, hs_data  OSERDES HS driver enable and parallel byte
//   lp_p, lp_n      LP Dp/Dn levels
//   stopstate, busy lane idle in LP-11 STOP / sequence in progress
//   err_underflow   one-cycle pulse when the payload stream starves
//   stat_bursts, stat_underflows  16-bit wrapping statistics counters
//
// Optional feature: define MIPI_DPHY_TX_HS_SEQ_STATS_EN to build the
// statistics counters; otherwise both stat ports are tied to zero.

module mipi_dphy_tx_hs_seq #(
  parameter int unsigned TIMER_BITS   = 8,
  parameter int unsigned T_LPX        = 4,
  parameter int unsigned T_HS_PREPARE = 3,
  parameter int unsigned T_HS_ZERO    = 10,
  parameter int unsigned T_HS_TRAIL   = 5,
  parameter int unsigned T_HS_EXIT    = 6,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        hs_oe,
  output logic [7:0]  hs_data,
  output logic        lp_p,
  output logic        lp_n,
  output logic        stopstate,
  output logic        busy,
  output logic        err_underflow,
  output logic [15:0] stat_bursts,
  output logic [15:0] stat_underflows
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAT_W = 16;

  localparam logic [TIMER_BITS-1:0] LD_LPX     = TIMER_BITS'(T_LPX - 1);
  localparam logic [TIMER_BITS-1:0] LD_PREPARE = TIMER_BITS'(T_HS_PREPARE - 1);
  localparam logic [TIMER_BITS-1:0] LD_ZERO    = TIMER_BITS'(T_HS_ZERO - 1);
  localparam logic [TIMER_BITS-1:0] LD_TRAIL   = TIMER_BITS'(T_HS_TRAIL - 1);
  localparam logic [TIMER_BITS-1:0] LD_EXIT    = TIMER_BITS'(T_HS_EXIT - 1);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_HS_RQST,
    ST_HS_PREPARE,
    ST_HS_ZERO,
    ST_HS_SYNC,
    ST_HS_DATA,
    ST_HS_TRAIL,
    ST_HS_EXIT
  } state_e;

  state_e                 state_q, state_d;
  logic [TIMER_BITS-1:0]  timer_q, timer_d;
  logic                   s_ready_q, s_ready_d;
  logic                   hs_oe_q, hs_oe_d;
  logic [DATA_W-1:0]      hs_data_q, hs_data_d;
  logic                   lp_p_q, lp_p_d;
  logic                   lp_n_q, lp_n_d;
  logic                   stopstate_q, stopstate_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   burst_done_c;
  logic                   timer_zero_c;
  logic [DATA_W-1:0]      trail_byte_c;

  assign timer_zero_c = (timer_q == '0);
  // Trail holds the inverse of the last serialized bit (bit 7 of the byte on the wire).
  assign trail_byte_c = {DATA_W{~hs_data_q[DATA_W-1]}};

  // Next-state, timer and registered-output computation.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_zero_c ? timer_q : TIMER_BITS'(timer_q - 1'b1);
    s_ready_d    = 1'b0;
    err_d        = 1'b0;
    hs_data_d    = hs_data_q;
    burst_done_c = 1'b0;

    unique case (state_q)
      ST_STOP: begin
        if (s_valid) begin
          state_d = ST_HS_RQST;
          timer_d = LD_LPX;
        end
      end
      ST_HS_RQST: begin
        if (timer_zero_c) begin
          state_d = ST_HS_PREPARE;
          timer_d = LD_PREPARE;
        end
      end
      ST_HS_PREPARE: begin
        if (timer_zero_c) begin
          state_d = ST_HS_ZERO;
          timer_d = LD_ZERO;
        end
      end
      ST_HS_ZERO: begin
        if (timer_zero_c) begin
          state_d   = ST_HS_SYNC;
          s_ready_d = 1'b1;
        end
      end
      // SYNC always has s_ready high; DATA drops it once the last byte is on the wire.
      ST_HS_SYNC, ST_HS_DATA: begin
        if (s_ready_q && s_valid) begin
          state_d   = ST_HS_DATA;
          hs_data_d = s_data;
          s_ready_d = ~s_last;
        end else begin
          // Either the last byte just went out or the stream starved.
          state_d   = ST_HS_TRAIL;
          timer_d   = LD_TRAIL;
          hs_data_d = trail_byte_c;
          err_d     = s_ready_q;
        end
      end
      ST_HS_TRAIL: begin
        if (timer_zero_c) begin
          state_d      = ST_HS_EXIT;
          timer_d      = LD_EXIT;
          burst_done_c = 1'b1;
        end
      end
      ST_HS_EXIT: begin
        if (timer_zero_c) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    // Line outputs follow the state being entered so they change with it.
    lp_p_d      = (state_d == ST_STOP) || (state_d == ST_HS_EXIT);
    lp_n_d      = (state_d == ST_STOP) || (state_d == ST_HS_EXIT) ||
                  (state_d == ST_HS_RQST);
    hs_oe_d     = (state_d == ST_HS_ZERO) || (state_d == ST_HS_SYNC) ||
                  (state_d == ST_HS_DATA) || (state_d == ST_HS_TRAIL);
    stopstate_d = (state_d == ST_STOP);
    busy_d      = ~stopstate_d;

    unique case (state_d)
      ST_HS_SYNC:               hs_data_d = SYNC_BYTE;
      ST_HS_DATA, ST_HS_TRAIL:  hs_data_d = hs_data_d;
      default:                  hs_data_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STOP;
      timer_q     <= '0;
      s_ready_q   <= 1'b0;
      hs_oe_q     <= 1'b0;
      hs_data_q   <= '0;
      lp_p_q      <= 1'b1;
      lp_n_q      <= 1'b1;
      stopstate_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      s_ready_q   <= s_ready_d;
      hs_oe_q     <= hs_oe_d;
      hs_data_q   <= hs_data_d;
      lp_p_q      <= lp_p_d;
      lp_n_q      <= lp_n_d;
      stopstate_q <= stopstate_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign hs_oe         = hs_oe_q;
  assign hs_data       = hs_data_q;
  assign lp_p          = lp_p_q;
  assign lp_n          = lp_n_q;
  assign stopstate     = stopstate_q;
  assign busy          = busy_q;
  assign err_underflow = err_q;

`ifdef MIPI_DPHY_TX_HS_SEQ_STATS_EN
  logic [STAT_W-1:0] bursts_q, bursts_d;
  logic [STAT_W-1:0] underflows_q, underflows_d;

  // Wrapping counters; underflow count moves together with the error pulse.
  always_comb begin
    bursts_d     = burst_done_c ? STAT_W'(bursts_q + 1'b1) : bursts_q;
    underflows_d = err_d ? STAT_W'(underflows_q + 1'b1) : underflows_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bursts_q     <= '0;
      underflows_q <= '0;
    end else begin
      bursts_q     <= bursts_d;
      underflows_q <= underflows_d;
    end
  end

  assign stat_bursts     = bursts_q;
  assign stat_underflows = underflows_q;
`else
  logic unused_stats_c;
  assign unused_stats_c  = burst_done_c;
  assign stat_bursts     = STAT_W'(0);
  assign stat_underflows = STAT_W'(0);
`endif

endmodule
